// File: rtl/usb_tx_line_driver.sv
// USB transmit line driver: registers NRZI data onto D+/D-, appends a programmable EOP, idles in J.
// Optional txd_oe output enable is built when TX_LINE_OE_EN is defined.
module usb_tx_line_driver #(
    parameter int unsigned EOP_SE0_CYCLES = 2,
    parameter int unsigned EOP_J_CYCLES   = 1,
    parameter bit          LOW_SPEED      = 1'b0
) (
    input  logic gclk,
    input  logic reset_l,
    input  logic nrzi_data,
    input  logic tx_data_valid,
    output logic txd_pos,
    output logic txd_neg,
    output logic tx_busy,
    output logic eop_done,
    output logic tx_err
`ifdef TX_LINE_OE_EN
    ,
    output logic txd_oe
`endif
);

    localparam logic [1:0] PAIR_J   = LOW_SPEED ? 2'b01 : 2'b10;
    localparam logic [1:0] PAIR_SE0 = 2'b00;
    localparam logic [3:0] SE0_LOAD = 4'(EOP_SE0_CYCLES - 1);
    localparam logic [3:0] J_LOAD   = (EOP_J_CYCLES > 1) ? 4'(EOP_J_CYCLES - 2) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        EOP_SE0,
        EOP_J
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       valid_q;
    logic       valid_rise;

    assign valid_rise = tx_data_valid & ~valid_q;

    // The final EOP J bit (with eop_done) is issued on the edge that returns to IDLE,
    // so a packet requested during that bit is accepted on the very next edge.
    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            state              <= IDLE;
            cnt                <= '0;
            valid_q            <= 1'b0;
            {txd_pos, txd_neg} <= PAIR_J;
            tx_busy            <= 1'b0;
            eop_done           <= 1'b0;
            tx_err             <= 1'b0;
        end else begin
            valid_q  <= tx_data_valid;
            eop_done <= 1'b0;
            tx_err   <= ((state == EOP_SE0) || (state == EOP_J)) && valid_rise;
            case (state)
                IDLE: begin
                    if (tx_data_valid) begin
                        state              <= DATA;
                        {txd_pos, txd_neg} <= {nrzi_data, ~nrzi_data};
                        tx_busy            <= 1'b1;
                    end else begin
                        {txd_pos, txd_neg} <= PAIR_J;
                        tx_busy            <= 1'b0;
                    end
                end
                DATA: begin
                    tx_busy <= 1'b1;
                    if (tx_data_valid) begin
                        {txd_pos, txd_neg} <= {nrzi_data, ~nrzi_data};
                    end else begin
                        state              <= EOP_SE0;
                        cnt                <= SE0_LOAD;
                        {txd_pos, txd_neg} <= PAIR_SE0;
                    end
                end
                EOP_SE0: begin
                    tx_busy <= 1'b1;
                    if (cnt != 4'd0) begin
                        cnt                <= cnt - 4'd1;
                        {txd_pos, txd_neg} <= PAIR_SE0;
                    end else begin
                        {txd_pos, txd_neg} <= PAIR_J;
                        if (EOP_J_CYCLES > 1) begin
                            state <= EOP_J;
                            cnt   <= J_LOAD;
                        end else begin
                            state    <= IDLE;
                            eop_done <= 1'b1;
                        end
                    end
                end
                EOP_J: begin
                    tx_busy            <= 1'b1;
                    {txd_pos, txd_neg} <= PAIR_J;
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state    <= IDLE;
                        eop_done <= 1'b1;
                    end
                end
                default: begin
                    state              <= IDLE;
                    {txd_pos, txd_neg} <= PAIR_J;
                    tx_busy            <= 1'b0;
                end
            endcase
        end
    end

`ifdef TX_LINE_OE_EN
    assign txd_oe = tx_busy;
`endif

endmodule

// File: tb/tb_usb_tx_line_driver.sv
// Bench for usb_tx_line_driver: three parameter sets driven in lockstep, checked against a
// symbol-schedule model every cycle plus hand-computed directed expectations.
module tb_usb_tx_line_driver;

    localparam int unsigned A_SE0 = 2, A_J = 1;
    localparam int unsigned B_SE0 = 3, B_J = 4;
    localparam int unsigned C_SE0 = 1, C_J = 2;

    logic gclk          = 1'b0;
    logic reset_l       = 1'b1;
    logic nrzi_data     = 1'b0;
    logic tx_data_valid = 1'b0;

    logic pos[3], neg[3], busy[3], done[3], err[3];
`ifdef TX_LINE_OE_EN
    logic oe[3];
`endif

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    always #5 gclk = ~gclk;

    usb_tx_line_driver #(.EOP_SE0_CYCLES(A_SE0), .EOP_J_CYCLES(A_J), .LOW_SPEED(1'b0)) dut_a (
        .gclk(gclk), .reset_l(reset_l), .nrzi_data(nrzi_data), .tx_data_valid(tx_data_valid),
        .txd_pos(pos[0]), .txd_neg(neg[0]), .tx_busy(busy[0]), .eop_done(done[0]), .tx_err(err[0])
`ifdef TX_LINE_OE_EN
        , .txd_oe(oe[0])
`endif
    );

    usb_tx_line_driver #(.EOP_SE0_CYCLES(B_SE0), .EOP_J_CYCLES(B_J), .LOW_SPEED(1'b0)) dut_b (
        .gclk(gclk), .reset_l(reset_l), .nrzi_data(nrzi_data), .tx_data_valid(tx_data_valid),
        .txd_pos(pos[1]), .txd_neg(neg[1]), .tx_busy(busy[1]), .eop_done(done[1]), .tx_err(err[1])
`ifdef TX_LINE_OE_EN
        , .txd_oe(oe[1])
`endif
    );

    usb_tx_line_driver #(.EOP_SE0_CYCLES(C_SE0), .EOP_J_CYCLES(C_J), .LOW_SPEED(1'b1)) dut_c (
        .gclk(gclk), .reset_l(reset_l), .nrzi_data(nrzi_data), .tx_data_valid(tx_data_valid),
        .txd_pos(pos[2]), .txd_neg(neg[2]), .tx_busy(busy[2]), .eop_done(done[2]), .tx_err(err[2])
`ifdef TX_LINE_OE_EN
        , .txd_oe(oe[2])
`endif
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an EOP is a schedule of se0+j symbols indexed by eop_pos; the last one carries eop_done.
    int   m_se0[3] = '{A_SE0, B_SE0, C_SE0};
    int   m_j[3]   = '{A_J, B_J, C_J};
    bit   m_ls[3]  = '{1'b0, 1'b0, 1'b1};
    int   eop_pos[3];
    bit   in_pkt[3];
    logic prev_valid;
    logic [1:0] e_pair[3];
    logic e_busy[3], e_done[3], e_err[3];

    always @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < 3; i++) begin
                eop_pos[i] = -1;
                in_pkt[i]  = 1'b0;
                e_pair[i]  = m_ls[i] ? 2'b01 : 2'b10;
                e_busy[i]  = 1'b0;
                e_done[i]  = 1'b0;
                e_err[i]   = 1'b0;
            end
            prev_valid = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                e_err[i]  = 1'b0;
                e_done[i] = 1'b0;
                if (eop_pos[i] >= 0) begin
                    e_err[i]  = tx_data_valid && !prev_valid;
                    e_busy[i] = 1'b1;
                    e_pair[i] = (eop_pos[i] < m_se0[i]) ? 2'b00 : (m_ls[i] ? 2'b01 : 2'b10);
                    if (eop_pos[i] == m_se0[i] + m_j[i] - 1) begin
                        e_done[i]  = 1'b1;
                        eop_pos[i] = -1;
                    end else begin
                        eop_pos[i]++;
                    end
                end else if (tx_data_valid) begin
                    e_pair[i] = {nrzi_data, ~nrzi_data};
                    e_busy[i] = 1'b1;
                    in_pkt[i] = 1'b1;
                end else if (in_pkt[i]) begin
                    in_pkt[i]  = 1'b0;
                    e_pair[i]  = 2'b00;
                    e_busy[i]  = 1'b1;
                    eop_pos[i] = 1;
                end else begin
                    e_pair[i] = m_ls[i] ? 2'b01 : 2'b10;
                    e_busy[i] = 1'b0;
                end
            end
            prev_valid = tx_data_valid;
        end
    end

    always @(negedge gclk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_%0d", i),
                    8'({pos[i], neg[i], busy[i], done[i], err[i]}),
                    8'({e_pair[i], e_busy[i], e_done[i], e_err[i]}));
`ifdef TX_LINE_OE_EN
                chk($sformatf("model_oe_%0d", i), 8'(oe[i]), 8'(e_busy[i]));
`endif
            end
        end
    end

    task automatic drive(input logic v, input logic d);
        tx_data_valid = v;
        nrzi_data     = d;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge gclk);
            drive(1'b0, k[0]);
        end
    endtask

    logic pkt[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int bbusy, bse0, bj, bdone_cnt, bdone_at;
    int cbusy, cse0, cj, cdone_at, coe;

    initial begin
        #1 reset_l = 1'b0;
        #12;
        chk("rst_a", 8'({pos[0], neg[0], busy[0], done[0], err[0]}), 8'b10000);
        chk("rst_c", 8'({pos[2], neg[2], busy[2], done[2], err[2]}), 8'b01000);
        @(negedge gclk);
        reset_l = 1'b1;
        chk_en  = 1'b1;
        drain(3);

        // 8-bit packet on the default instance
        for (int k = 0; k <= 8; k++) begin
            @(negedge gclk);
            if (k > 0)
                chk("t2_data", 8'({pos[0], neg[0], busy[0]}), 8'({pkt[k-1], ~pkt[k-1], 1'b1}));
            if (k < 8) drive(1'b1, pkt[k]);
            else       drive(1'b0, 1'b1);
        end
        @(negedge gclk); chk("t2_se0_1", 8'({pos[0], neg[0], busy[0], done[0]}), 8'b0010);
        @(negedge gclk); chk("t2_se0_2", 8'({pos[0], neg[0], busy[0], done[0]}), 8'b0010);
        @(negedge gclk); chk("t2_eop_j", 8'({pos[0], neg[0], busy[0], done[0]}), 8'b1011);
        @(negedge gclk); chk("t2_idle",  8'({pos[0], neg[0], busy[0], done[0]}), 8'b1000);
        drain(10);

        // 1-bit packet: long EOP on B, low-speed on C
        bbusy = 0; bse0 = 0; bj = 0; bdone_cnt = 0; bdone_at = -1;
        cbusy = 0; cse0 = 0; cj = 0; cdone_at = -1; coe = 0;
        @(negedge gclk); drive(1'b1, 1'b1);
        for (int n = 0; n < 14; n++) begin
            @(negedge gclk);
            if (n == 0) drive(1'b0, 1'b0);
            if (busy[1]) bbusy++;
            if ({pos[1], neg[1]} == 2'b00) bse0++;
            if (bse0 > 0 && busy[1] && {pos[1], neg[1]} == 2'b10) bj++;
            if (done[1]) begin bdone_cnt++; bdone_at = bj; end
            if (busy[2]) cbusy++;
            if ({pos[2], neg[2]} == 2'b00) cse0++;
            if (cse0 > 0 && busy[2] && {pos[2], neg[2]} == 2'b01) cj++;
            if (done[2]) cdone_at = cj;
`ifdef TX_LINE_OE_EN
            if (oe[2]) coe++;
`endif
        end
        chk("t3_busy",    8'(bbusy), 8'd8);
        chk("t3_se0",     8'(bse0), 8'd3);
        chk("t3_j",       8'(bj), 8'd4);
        chk("t3_done_n",  8'(bdone_cnt), 8'd1);
        chk("t3_done_at", 8'(bdone_at), 8'd4);
        chk("t6_busy",    8'(cbusy), 8'd4);
        chk("t6_se0",     8'(cse0), 8'd1);
        chk("t6_j",       8'(cj), 8'd2);
        chk("t6_done_at", 8'(cdone_at), 8'd2);
        chk("t6_idle",    8'({pos[2], neg[2], busy[2]}), 8'b010);
`ifdef TX_LINE_OE_EN
        chk("t6_oe",      8'(coe), 8'd4);
`endif
        drain(2);

        // valid re-raised one cycle into EOP_SE0
        @(negedge gclk); drive(1'b1, 1'b1);
        @(negedge gclk); drive(1'b1, 1'b0);
        @(negedge gclk); drive(1'b0, 1'b0);
        @(negedge gclk);
        chk("t4_se0",  8'({pos[0], neg[0], busy[0], done[0], err[0]}), 8'b00100);
        drive(1'b1, 1'b1);
        @(negedge gclk);
        chk("t4_err",  8'({pos[0], neg[0], busy[0], done[0], err[0]}), 8'b00101);
        drive(1'b1, 1'b0);
        @(negedge gclk);
        chk("t4_done", 8'({pos[0], neg[0], busy[0], done[0], err[0]}), 8'b10110);
        drive(1'b1, 1'b1);
        @(negedge gclk);
        chk("t4_next", 8'({pos[0], neg[0], busy[0], done[0], err[0]}), 8'b10100);
        drain(14);

        // back-to-back: valid raised during eop_done
        @(negedge gclk); drive(1'b1, 1'b0);
        @(negedge gclk); drive(1'b0, 1'b0);
        @(negedge gclk); chk("t5_se0_1", 8'({pos[0], neg[0], busy[0], done[0], err[0]}), 8'b00100);
        @(negedge gclk); chk("t5_se0_2", 8'({pos[0], neg[0], busy[0], done[0], err[0]}), 8'b00100);
        @(negedge gclk); chk("t5_done",  8'({pos[0], neg[0], busy[0], done[0], err[0]}), 8'b10110);
        drive(1'b1, 1'b0);
        @(negedge gclk); chk("t5_data",  8'({pos[0], neg[0], busy[0], done[0], err[0]}), 8'b01100);
        drain(14);

        // asynchronous reset mid-DATA
        @(negedge gclk); drive(1'b1, 1'b0);
        @(negedge gclk); drive(1'b1, 1'b0);
        #2 reset_l = 1'b0;
        #1;
        chk("t1_rst_a", 8'({pos[0], neg[0], busy[0], done[0], err[0]}), 8'b10000);
        chk("t1_rst_b", 8'({pos[1], neg[1], busy[1], done[1], err[1]}), 8'b10000);
        chk("t1_rst_c", 8'({pos[2], neg[2], busy[2], done[2], err[2]}), 8'b01000);
        @(negedge gclk); drive(1'b0, 1'b0);
        @(negedge gclk); reset_l = 1'b1;
        drain(3);
        chk("t1_after", 8'({pos[0], neg[0], busy[0], done[0], err[0]}), 8'b10000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
